pim_bloom_scan: RTL and testbench
=================================

# pim_bloom_scan

Parametrised successor to the single-block PIM top. It merges the peak memory and the scan core into one block and adds a host load port and a start/busy/done handshake. Each pass scans every entry; an explicit mode selects clear, reference search or bloom marking, with a configurable signal threshold and distance tolerance. The block sits between the row sequencer and the per-block peak store, one instance per block.

## Interface
- BLOCK_SIZE, 30, number of entries (≤ 2^ADDR_WIDTH)
- SIGNAL_WIDTH, 18, peak signal width
- DIST_WIDTH, 14, peak distance width
- NOT_WIDTH, 2, per-entry notation width
- PEAK_NUM, 4, peaks per entry
- ADDR_WIDTH, 5, entry address width
- REF_THRESH, 1000, signal threshold; ≥ means ref-class, < means bloom-class
- DIST_TOL, 4, max |distance difference| counted as a match
- Entry data = PEAK_NUM × {signal, dist}. Peak 0 is in the LSBs; dist is the low DIST_WIDTH bits of each peak.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pass request, sampled only in IDLE
- mode  in  2  pass type: 00 CLEAR, 01 REF, 10 BLOOM, 11 reserved
- distance  in  DIST_WIDTH  target distance for a REF pass, sampled with start
- ld_valid  in  1  load strobe
- ld_addr  in  ADDR_WIDTH  load address
- ld_data  in  (SIGNAL_WIDTH+DIST_WIDTH)*PEAK_NUM  load data
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass
- contains_ref  out  1  sticky: a ref entry was found
- contains_bloom  out  1  sticky: a bloom entry was marked
- ref_dist  out  DIST_WIDTH  distance of the first ref peak found
- bloom_cnt  out  ADDR_WIDTH+1  present only with PIM_BLOOM_CNT_EN

## Operation
- Notation encoding: 00 none, 01 ref, 10 bloom, 11 unused (never written).
- Storage:
  - Data array has a synchronous read and is not reset.
  - Notation array is flops, reset to 00.
- Load port:
  - Accepted only when busy=0 and ld_addr < BLOCK_SIZE; otherwise ignored.
  - Writes the data word and clears that entry's notation to 00.
- FSM states: IDLE → RD → EV → (RD for the next entry | FIN) → IDLE.
  - IDLE: on start=1 with mode≠11, latch mode and distance, set address 0, go to RD.
  - IDLE: on start=1 with mode=11, go to FIN directly with no effect.
  - RD: issue read of entry addr.
  - EV: evaluate and write back notation. Go to RD with addr+1, or to FIN after entry BLOCK_SIZE-1.
  - FIN: done=1, go to IDLE.
- Match test: |peak.dist − target| ≤ DIST_TOL, computed on a DIST_WIDTH+1-bit unsigned difference, no wrap.
- CLEAR pass: every notation ← 00. At FIN, contains_ref, contains_bloom and ref_dist ← 0 (and bloom_cnt ← 0 if present).
- REF pass:
  - At start, contains_ref ← 0.
  - For each entry with notation 00, find the lowest-index peak with signal ≥ REF_THRESH that matches the latched distance. If found: notation ← 01, contains_ref ← 1.
  - ref_dist is loaded from the first such peak in address order of this pass.
- BLOOM pass:
  - At start, contains_bloom ← 0 (and bloom_cnt ← 0).
  - If contains_ref=0, the pass runs full length but marks nothing.
  - Otherwise, each entry with notation 00 that has any peak with signal < REF_THRESH matching ref_dist gets notation ← 10 and contains_bloom ← 1.
  - Entries marked 01 are never overwritten.
- start while busy=1 is ignored. ld_valid while busy=1 is ignored; no data is lost from memory.

## Timing
- Reset values:
  - busy, done, contains_ref, contains_bloom, ref_dist: 0.
  - All notations 00; FSM in IDLE; bloom_cnt 0.
- Pass timing, with start sampled at edge 0:
  - busy=1 from cycle 1.
  - Entry k is read in cycle 1+2k and written in cycle 2+2k.
  - done=1 and busy=0 in cycle 2·BLOCK_SIZE+1.
  - Next start is accepted from cycle 2·BLOCK_SIZE+2.
- Reserved mode: busy stays 0; done pulses in cycle 1.
- Flags and ref_dist update at the EV edge of the matching entry.
- Load write completes the cycle after ld_valid. Loading address k and then starting a pass in the next cycle sees the new data.
- rst asserted mid-pass:
  - Immediate return to IDLE; all outputs and notations go to their reset values.
  - Data array is untouched.

## Configuration
- PIM_BLOOM_CNT_EN defined:
  - bloom_cnt port exists and counts entries marked 10 in the current BLOOM pass.
  - It saturates at BLOCK_SIZE, holds after done, and clears at BLOOM start, at CLEAR FIN and on reset.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: rst=1 for 3 cycles mid-REF-pass → busy=0, done=0, flags 0, ref_dist=0. A following BLOOM pass marks nothing (contains_bloom=0).
- REF pass, distance=500: entry 3 has peak {1200, 502}, entry 7 has {1500, 498}, no other matches → done at cycle 61, contains_ref=1, ref_dist=502, entries 3 and 7 marked 01.
- BLOOM after the REF above: entry 9 has {200, 505}, entry 10 has {200, 507} → entry 9 marked 10, entry 10 stays 00, contains_bloom=1, bloom_cnt=1 with PIM_BLOOM_CNT_EN.
- Handshake: start pulsed every cycle during a pass and ld_valid during a pass → ignored, memory unchanged. Mode 11 → done in cycle 1 and busy never set.
- CLEAR after REF+BLOOM → all notations 00, contains_ref=contains_bloom=0, ref_dist=0 at the done cycle.
- Boundary: peak dist 0 with distance=3 matches (no wrap); dist 16383 with distance=0 does not match. ld_addr=30 is ignored; a match in entry 29 is marked.

Source files
------------

// File: rtl/pim_bloom_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : pim_bloom_scan_if
//  Description : Host-side bundle for pim_bloom_scan. Carries the pass
//                handshake (start/mode/distance/busy/done), the entry load
//                port and the scan result flags. The bloom_cnt member exists
//                only when PIM_BLOOM_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pim_bloom_scan_if #(
  parameter int SIGNAL_WIDTH = 18,
  parameter int DIST_WIDTH   = 14,
  parameter int PEAK_NUM     = 4,
  parameter int ADDR_WIDTH   = 5
);
  // pass request
  logic                                        start;
  logic [1:0]                                  mode;
  logic [DIST_WIDTH-1:0]                       distance;
  // entry load port
  logic                                        ld_valid;
  logic [ADDR_WIDTH-1:0]                       ld_addr;
  logic [(SIGNAL_WIDTH+DIST_WIDTH)*PEAK_NUM-1:0] ld_data;
  // status / results
  logic                                        busy;
  logic                                        done;
  logic                                        contains_ref;
  logic                                        contains_bloom;
  logic [DIST_WIDTH-1:0]                       ref_dist;
`ifdef PIM_BLOOM_CNT_EN
  logic [ADDR_WIDTH:0]                         bloom_cnt;

  modport master (
    output start, mode, distance, ld_valid, ld_addr, ld_data,
    input  busy, done, contains_ref, contains_bloom, ref_dist, bloom_cnt
  );

  modport slave (
    input  start, mode, distance, ld_valid, ld_addr, ld_data,
    output busy, done, contains_ref, contains_bloom, ref_dist, bloom_cnt
  );
`else
  modport master (
    output start, mode, distance, ld_valid, ld_addr, ld_data,
    input  busy, done, contains_ref, contains_bloom, ref_dist
  );

  modport slave (
    input  start, mode, distance, ld_valid, ld_addr, ld_data,
    output busy, done, contains_ref, contains_bloom, ref_dist
  );
`endif
endinterface
`default_nettype wire

// File: rtl/pim_bloom_scan.sv
`default_nettype none
// ============================================================================
//  Module      : pim_bloom_scan
//  Description : Per-block peak store with built-in scan engine. A pass
//                walks every entry (read cycle, evaluate/write-back cycle)
//                and either clears notations, marks reference entries that
//                match a target distance, or marks bloom entries matching
//                the stored reference distance. Host loads entries through
//                a load port while idle.
//                Optional macro PIM_BLOOM_CNT_EN adds the bloom_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module pim_bloom_scan #(
  parameter int BLOCK_SIZE   = 30,
  parameter int SIGNAL_WIDTH = 18,
  parameter int DIST_WIDTH   = 14,
  parameter int NOT_WIDTH    = 2,
  parameter int PEAK_NUM     = 4,
  parameter int ADDR_WIDTH   = 5,
  parameter int REF_THRESH   = 1000,
  parameter int DIST_TOL     = 4
) (
  input wire              clk,
  input wire              rst,
  pim_bloom_scan_if.slave bus
);

  localparam int c_peak_w = SIGNAL_WIDTH + DIST_WIDTH;
  localparam int c_data_w = c_peak_w * PEAK_NUM;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_rd   = 2'd1;
  localparam logic [1:0] c_st_ev   = 2'd2;
  localparam logic [1:0] c_st_fin  = 2'd3;

  localparam logic [1:0] c_mode_clear = 2'b00;
  localparam logic [1:0] c_mode_ref   = 2'b01;
  localparam logic [1:0] c_mode_bloom = 2'b10;
  localparam logic [1:0] c_mode_rsvd  = 2'b11;

  localparam logic [NOT_WIDTH-1:0] c_note_none  = NOT_WIDTH'(0);
  localparam logic [NOT_WIDTH-1:0] c_note_ref   = NOT_WIDTH'(1);
  localparam logic [NOT_WIDTH-1:0] c_note_bloom = NOT_WIDTH'(2);

  localparam logic [SIGNAL_WIDTH-1:0] c_thresh = SIGNAL_WIDTH'(REF_THRESH);
  localparam logic [DIST_WIDTH:0]     c_tol    = (DIST_WIDTH+1)'(DIST_TOL);
  localparam logic [ADDR_WIDTH:0]     c_size   = (ADDR_WIDTH+1)'(BLOCK_SIZE);
  localparam logic [ADDR_WIDTH-1:0]   c_last   = ADDR_WIDTH'(BLOCK_SIZE - 1);

  // FSM
  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic                    w_busy;
  logic                    w_done;
  logic                    w_pass_start;
  logic                    w_rd;
  logic                    w_ev;
  logic                    w_ld_ok;
  logic                    w_last;

  // pass context and results
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [1:0]              r_mode;
  logic [DIST_WIDTH-1:0]   r_target;
  logic                    r_contains_ref;
  logic                    r_contains_bloom;
  logic [DIST_WIDTH-1:0]   r_ref_dist;
`ifdef PIM_BLOOM_CNT_EN
  logic [ADDR_WIDTH:0]     r_bloom_cnt;
`endif

  // storage
  logic [c_data_w-1:0]     r_mem  [0:BLOCK_SIZE-1];
  logic [NOT_WIDTH-1:0]    r_note [0:BLOCK_SIZE-1];
  logic [c_data_w-1:0]     r_rd_data;

  // evaluation
  logic [SIGNAL_WIDTH-1:0] w_sig  [0:PEAK_NUM-1];
  logic [DIST_WIDTH-1:0]   w_dist [0:PEAK_NUM-1];
  logic [NOT_WIDTH-1:0]    w_cur_note;
  logic                    w_ref_hit;
  logic [DIST_WIDTH-1:0]   w_ref_hit_dist;
  logic                    w_bloom_hit;
  logic                    w_ref_mark;
  logic                    w_bloom_mark;

  // Absolute distance difference on one extra bit so it can never wrap.
  function automatic logic dist_match(input logic [DIST_WIDTH-1:0] a,
                                      input logic [DIST_WIDTH-1:0] b);
    logic [DIST_WIDTH:0] diff;
    if (a >= b) diff = {1'b0, a} - {1'b0, b};
    else        diff = {1'b0, b} - {1'b0, a};
    return (diff <= c_tol);
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: reserved mode skips straight to FIN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (bus.start) begin
          if (bus.mode == c_mode_rsvd) w_state_nxt = c_st_fin;
          else                         w_state_nxt = c_st_rd;
        end
      end
      c_st_rd:  w_state_nxt = c_st_ev;
      c_st_ev:  w_state_nxt = w_last ? c_st_fin : c_st_rd;
      default:  w_state_nxt = c_st_idle;
    endcase
  end

  // Output decode: status outputs and per-state strobes.
  always_comb begin
    w_busy       = (r_state == c_st_rd) || (r_state == c_st_ev);
    w_done       = (r_state == c_st_fin);
    w_rd         = (r_state == c_st_rd);
    w_ev         = (r_state == c_st_ev);
    w_pass_start = (r_state == c_st_idle) && bus.start && (bus.mode != c_mode_rsvd);
    w_ld_ok      = bus.ld_valid && !w_busy && ({1'b0, bus.ld_addr} < c_size);
  end

  assign w_last     = (r_addr == c_last);
  assign w_cur_note = r_note[r_addr];

  // Split the read word into per-peak signal and distance fields.
  generate
    for (genvar p = 0; p < PEAK_NUM; p++) begin : g_peak
      assign w_dist[p] = r_rd_data[p*c_peak_w +: DIST_WIDTH];
      assign w_sig[p]  = r_rd_data[p*c_peak_w + DIST_WIDTH +: SIGNAL_WIDTH];
    end
  endgenerate

  // Peak evaluation; descending walk so the lowest-index ref peak wins.
  always_comb begin
    w_ref_hit      = 1'b0;
    w_ref_hit_dist = '0;
    w_bloom_hit    = 1'b0;
    for (int p = PEAK_NUM - 1; p >= 0; p--) begin
      if ((w_sig[p] >= c_thresh) && dist_match(w_dist[p], r_target)) begin
        w_ref_hit      = 1'b1;
        w_ref_hit_dist = w_dist[p];
      end
      if ((w_sig[p] < c_thresh) && dist_match(w_dist[p], r_ref_dist)) begin
        w_bloom_hit = 1'b1;
      end
    end
    w_ref_mark   = w_ev && (r_mode == c_mode_ref) &&
                   (w_cur_note == c_note_none) && w_ref_hit;
    w_bloom_mark = w_ev && (r_mode == c_mode_bloom) && r_contains_ref &&
                   (w_cur_note == c_note_none) && w_bloom_hit;
  end

  // Data array: host writes plus the synchronous scan read, never reset.
  always_ff @(posedge clk) begin
    if (w_ld_ok) r_mem[bus.ld_addr] <= bus.ld_data;
    if (w_rd)    r_rd_data <= r_mem[r_addr];
  end

  // Notation array: a load invalidates the entry, EV writes back the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BLOCK_SIZE; i++) r_note[i] <= c_note_none;
    end else if (w_ld_ok) begin
      r_note[bus.ld_addr] <= c_note_none;
    end else if (w_ev) begin
      if (r_mode == c_mode_clear) r_note[r_addr] <= c_note_none;
      else if (w_ref_mark)        r_note[r_addr] <= c_note_ref;
      else if (w_bloom_mark)      r_note[r_addr] <= c_note_bloom;
    end
  end

  // Pass context, address walk and sticky result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr           <= '0;
      r_mode           <= c_mode_clear;
      r_target         <= '0;
      r_contains_ref   <= 1'b0;
      r_contains_bloom <= 1'b0;
      r_ref_dist       <= '0;
`ifdef PIM_BLOOM_CNT_EN
      r_bloom_cnt      <= '0;
`endif
    end else begin
      if (w_pass_start) begin
        r_addr   <= '0;
        r_mode   <= bus.mode;
        r_target <= bus.distance;
        if (bus.mode == c_mode_ref) r_contains_ref <= 1'b0;
        if (bus.mode == c_mode_bloom) begin
          r_contains_bloom <= 1'b0;
`ifdef PIM_BLOOM_CNT_EN
          r_bloom_cnt      <= '0;
`endif
        end
      end
      if (w_ev) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        // Clearing the flags on the last EV edge makes them read 0 with done.
        if ((r_mode == c_mode_clear) && w_last) begin
          r_contains_ref   <= 1'b0;
          r_contains_bloom <= 1'b0;
          r_ref_dist       <= '0;
`ifdef PIM_BLOOM_CNT_EN
          r_bloom_cnt      <= '0;
`endif
        end
        if (w_ref_mark) begin
          r_contains_ref <= 1'b1;
          // The flag was cleared at start, so a low flag means first hit.
          if (!r_contains_ref) r_ref_dist <= w_ref_hit_dist;
        end
        if (w_bloom_mark) begin
          r_contains_bloom <= 1'b1;
`ifdef PIM_BLOOM_CNT_EN
          if (r_bloom_cnt < c_size) r_bloom_cnt <= r_bloom_cnt + (ADDR_WIDTH+1)'(1);
`endif
        end
      end
    end
  end

  assign bus.busy           = w_busy;
  assign bus.done           = w_done;
  assign bus.contains_ref   = r_contains_ref;
  assign bus.contains_bloom = r_contains_bloom;
  assign bus.ref_dist       = r_ref_dist;
`ifdef PIM_BLOOM_CNT_EN
  assign bus.bloom_cnt      = r_bloom_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pim_bloom_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pim_bloom_scan
//  Description : Directed plus randomized bench for pim_bloom_scan with a
//                behavioural model of entries, notations and result flags.
//                bloom_cnt is checked when PIM_BLOOM_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pim_bloom_scan;

  localparam int BS = 30;

  logic clk;
  logic rst;

  pim_bloom_scan_if #(.SIGNAL_WIDTH(18), .DIST_WIDTH(14), .PEAK_NUM(4), .ADDR_WIDTH(5)) bus ();

  pim_bloom_scan #(
    .BLOCK_SIZE(BS), .SIGNAL_WIDTH(18), .DIST_WIDTH(14), .NOT_WIDTH(2),
    .PEAK_NUM(4), .ADDR_WIDTH(5), .REF_THRESH(1000), .DIST_TOL(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model
  logic [127:0] mem_m  [0:BS-1];
  int           note_m [0:BS-1];
  int           m_cref, m_cbl, m_rdist, m_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] peak(input int sig, input int dst);
    logic [17:0] s;
    logic [13:0] d;
    s = 18'(sig);
    d = 14'(dst);
    return {s, d};
  endfunction

  function automatic logic [31:0] filler();
    return peak($urandom_range(0, 262143), $urandom_range(12000, 16000));
  endfunction

  function automatic bit near(input int a, input int b);
    return ((a > b) ? (a - b) : (b - a)) <= 4;
  endfunction

  task automatic load(input int a, input logic [127:0] dat);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 5'(a);
    bus.ld_data  = dat;
    tick();
    bus.ld_valid = 1'b0;
    if (a < BS) begin
      mem_m[a]  = dat;
      note_m[a] = 0;
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < BS; e++) note_m[e] = 0;
    m_cref = 0; m_cbl = 0; m_rdist = 0; m_cnt = 0;
  endtask

  // One pass expressed directly from the scan rules.
  task automatic model_pass(input int m, input int d);
    logic [31:0] pk;
    int sig, dst;
    bit hit;
    case (m)
      0: model_reset();
      1: begin
        m_cref = 0;
        for (int e = 0; e < BS; e++) begin
          if (note_m[e] == 0) begin
            for (int p = 0; p < 4; p++) begin
              pk = mem_m[e][p*32 +: 32];
              sig = int'(pk[31:14]);
              dst = int'(pk[13:0]);
              if (sig >= 1000 && near(dst, d)) begin
                note_m[e] = 1;
                if (m_cref == 0) m_rdist = dst;
                m_cref = 1;
                break;
              end
            end
          end
        end
      end
      2: begin
        m_cbl = 0;
        m_cnt = 0;
        if (m_cref != 0) begin
          for (int e = 0; e < BS; e++) begin
            hit = 1'b0;
            for (int p = 0; p < 4; p++) begin
              pk = mem_m[e][p*32 +: 32];
              sig = int'(pk[31:14]);
              dst = int'(pk[13:0]);
              if (sig < 1000 && near(dst, m_rdist)) hit = 1'b1;
            end
            if (note_m[e] == 0 && hit) begin
              note_m[e] = 2;
              m_cbl = 1;
              m_cnt++;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_cref"},  32'(bus.contains_ref),   32'(m_cref));
    chk({tag, "_cbl"},   32'(bus.contains_bloom), 32'(m_cbl));
    chk({tag, "_rdist"}, 32'(bus.ref_dist),       32'(m_rdist));
`ifdef PIM_BLOOM_CNT_EN
    chk({tag, "_cnt"},   32'(bus.bloom_cnt),      32'(m_cnt));
`endif
  endtask

  task automatic check_notes(input string tag);
    for (int e = 0; e < BS; e++)
      chk($sformatf("%s_note%0d", tag, e), 32'(dut.r_note[e]), 32'(note_m[e]));
  endtask

  // Full pass with timing checks; hammer drives start and ld_valid while busy.
  task automatic run_pass(input int m, input int d, input bit hammer, input string tag);
    int cyc;
    bus.mode     = 2'(m);
    bus.distance = 14'(d);
    bus.start    = 1'b1;
    tick();
    cyc = 1;
    bus.start    = hammer;
    bus.ld_valid = hammer;
    bus.ld_addr  = 5'd3;
    bus.ld_data  = {$urandom, $urandom, $urandom, $urandom};
    chk({tag, "_busy_c1"}, 32'(bus.busy), (m == 3) ? 32'd0 : 32'd1);
    while (!bus.done && cyc < 200) begin
      tick();
      cyc++;
    end
    bus.start    = 1'b0;
    bus.ld_valid = 1'b0;
    chk({tag, "_done_cycle"}, 32'(cyc), (m == 3) ? 32'd1 : 32'(2*BS + 1));
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    model_pass(m, d);
    check_flags(tag);
    check_notes(tag);
    tick();
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 2'b00; bus.distance = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset values
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    check_flags("rst");
    check_notes("rst");

    // fill block, then plant the directed peaks
    for (int e = 0; e < BS; e++) load(e, {filler(), filler(), filler(), filler()});
    load(3,  {filler(), filler(), peak(1200, 502), filler()});
    load(7,  {filler(), filler(), filler(), peak(1500, 498)});
    load(9,  {filler(), peak(200, 505), filler(), filler()});
    load(10, {peak(200, 507), filler(), filler(), filler()});

    // reset in the middle of a REF pass
    bus.mode = 2'b01; bus.distance = 14'd500; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    chk("midrst_busy3", 32'(bus.busy), 32'd0);
    chk("midrst_done3", 32'(bus.done), 32'd0);
    check_flags("midrst");
    check_notes("midrst");
    rst = 1'b0;
    tick();
    run_pass(2, 0, 1'b0, "bloom_after_rst");
    chk("bloom_after_rst_none", 32'(bus.contains_bloom), 32'd0);

    // directed REF then BLOOM
    run_pass(1, 500, 1'b0, "ref500");
    chk("ref500_dist502", 32'(bus.ref_dist), 32'd502);
    chk("ref500_e3", 32'(dut.r_note[3]), 32'd1);
    chk("ref500_e7", 32'(dut.r_note[7]), 32'd1);
    run_pass(2, 0, 1'b0, "bloom1");
    chk("bloom1_e9", 32'(dut.r_note[9]), 32'd2);
    chk("bloom1_e10", 32'(dut.r_note[10]), 32'd0);
    chk("bloom1_flag", 32'(bus.contains_bloom), 32'd1);

    // start and loads hammered while busy must be ignored
    run_pass(1, 500, 1'b1, "hammer");
    run_pass(0, 0, 1'b0, "clear1");
    chk("clear1_rdist0", 32'(bus.ref_dist), 32'd0);
    run_pass(1, 500, 1'b0, "ref_again");
    chk("ref_again_502", 32'(bus.ref_dist), 32'd502);

    // reserved mode
    run_pass(3, 0, 1'b0, "rsvd");

    // boundaries: no wrap in distance difference, last entry, out-of-range load
    run_pass(0, 0, 1'b0, "clear2");
    load(0, {filler(), filler(), filler(), peak(1200, 0)});
    run_pass(1, 3, 1'b0, "dist0_t3");
    chk("dist0_t3_e0", 32'(dut.r_note[0]), 32'd1);
    run_pass(0, 0, 1'b0, "clear3");
    load(0, {filler(), filler(), filler(), peak(1200, 16383)});
    load(30, {peak(1200, 0), peak(1200, 0), peak(1200, 0), peak(1200, 0)});
    load(29, {filler(), peak(1200, 9000), filler(), filler()});
    run_pass(1, 0, 1'b0, "dist16383_t0");
    chk("dist16383_t0_none", 32'(bus.contains_ref), 32'd0);
    run_pass(1, 9002, 1'b0, "last_entry");
    chk("last_entry_e29", 32'(dut.r_note[29]), 32'd1);

    // randomized rounds
    for (int r = 0; r < 4; r++) begin
      t = $urandom_range(100, 140);
      for (int k = 0; k < 8; k++)
        load($urandom_range(0, 31),
             {peak($urandom_range(0, 1999), $urandom_range(t-8, t+8)),
              peak($urandom_range(0, 1999), $urandom_range(t-8, t+8)),
              peak($urandom_range(0, 1999), $urandom_range(t-8, t+8)),
              peak($urandom_range(0, 1999), $urandom_range(t-8, t+8))});
      if (r % 2 == 1) run_pass(0, 0, 1'b0, $sformatf("rnd%0d_clr", r));
      run_pass(1, t, 1'b0, $sformatf("rnd%0d_ref", r));
      run_pass(2, 0, 1'b0, $sformatf("rnd%0d_bloom", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
